pb3_l_roll_seq: RTL
===================

// Module: pb3_l_roll_seq
// PURPOSE
//  Multi-cycle roll/shift sequencer for the L (link) flag and the AC register.
//  Steps AC one bit per clk1 for N steps and drives the J/K controls of the L flip-flop.
//  Arbitrates microcode CLL#/CPL# against the running sequence.
//  Sits on the processor board between the microcode control bus, the L flip-flop and AC shift enables.
// PARAMETERS
//  CNT_W   4   width of step count; count==0 encodes 2**CNT_W steps (16 = full word)
// PORTS
//  clk1      in   1      processor clock, all state changes on rising edge
//  nreset    in   1      asynchronous, active-low reset
//  nstart    in   1      start request, active low, sampled on clk1 in IDLE only
//  dir       in   1      0 = left (towards bit 15), 1 = right
//  mode      in   2      00 rotate through L, 01 rotate AC only, 10 logical shift, 11 arith shift
//  count     in   CNT_W  number of single-bit steps (0 = 2**CNT_W)
//  ncll      in   1      microcode clear-L, active low
//  ncpl      in   1      microcode complement-L, active low
//  fl        in   1      current L flip-flop output
//  ac_msb    in   1      AC bit 15
//  ac_lsb    in   1      AC bit 0
//  lj        out  1      J input of L flip-flop
//  lk        out  1      K input of L flip-flop
//  ac_shl    out  1      AC shift-left enable for this edge
//  ac_shr    out  1      AC shift-right enable for this edge
//  ac_fill   out  1      bit shifted into AC (bit 0 if left, bit 15 if right)
//  busy      out  1      high from the edge accepting nstart until the DONE state is left
//  ndone     out  1      active low, exactly one cycle, in DONE state
// BEHAVIOUR
//  Reset (async, nreset low): state=IDLE, step counter=0, pending CLL/CPL=0.
//   Outputs: lj=lk=0, ac_shl=ac_shr=0, ac_fill=0, busy=0, ndone=1.
//  FSM: IDLE -> ROLL -> DONE -> IDLE.
//  IDLE
//   - nstart low at an edge: load cnt = count (0 -> 2**CNT_W), latch dir/mode, go to ROLL.
//   - ncll/ncpl act directly on L:
//       CLL only -> J=0,K=1.  CPL only -> J=1,K=1.  Both -> J=1,K=0 (set; CLL then CPL).
//  ROLL (one step per cycle)
//   - Asserts ac_shl (dir=0) or ac_shr (dir=1); cnt decrements each edge.
//   - Exits to DONE on the edge where cnt==1.
//   - Latency: nstart edge + N ROLL cycles + 1 DONE cycle.
//  Per step, with out = ac_msb (left) or ac_lsb (right):
//   - mode 00: fill=fl;  L<=out  (J=out, K=~out)
//   - mode 01: fill=out; L unchanged (J=K=0)
//   - mode 10: fill=0;   L<=out
//   - mode 11: right -> fill=ac_msb, L<=ac_lsb; left -> same as mode 10
//  ncll/ncpl low during ROLL: OR-latched into pend_cll/pend_cpl; never disturb a step.
//  nstart during ROLL or DONE: ignored, not queued.
//  DONE (one cycle)
//   - ndone=0, busy=1.
//   - Pending plus same-cycle ncll/ncpl applied to L with the IDLE encoding; pending cleared; go to IDLE.
//  nreset low mid-sequence: immediate IDLE; AC/L keep partially rolled values; pending discarded.
// CONFIGURATION
//  PB3_ROLL_ABORT_EN defined:
//   - adds input nabort (active low).
//   - nabort low during ROLL: no shift that cycle; next edge -> DONE, remaining steps dropped.
//   - nabort is ignored in IDLE/DONE.
//  PB3_ROLL_ABORT_EN undefined: port absent; every sequence runs all N steps.
// STRUCTURE
//  Package pb3_roll_pkg:
//   - state encodings ST_IDLE/ST_ROLL/ST_DONE
//   - mode constants MODE_RCL, MODE_ROT, MODE_SHL, MODE_ASR
//   - J/K command constants LCMD_HOLD/CLR/SET/TGL
//  Sub-module pb3_l_jk_enc (combinational):
//   - maps {step_active, mode, dir, fl, ac_msb, ac_lsb, cll, cpl} to {lj, lk, ac_fill}
//   - keeps the FSM/counter file free of the per-mode table.
// TESTING
//  T1 Rotate through L:
//     AC=8001h, L=0, mode=00, dir=0, count=1
//     -> 1 ROLL cycle; AC=0002h, L=1; ndone low 2nd cycle after start edge.
//  T2 Full word:
//     AC=1234h, L=1, mode=01, count=0
//     -> exactly 16 ac_shl pulses; AC=1234h, L=1; busy high 17 cycles.
//  T3 Arith shift right:
//     AC=8004h, mode=11, dir=1, count=3
//     -> AC=F000h, L=1 (bit 2 shifted out last).
//  T4 Arbitration:
//     CPL# pulsed in ROLL step 2 of 4, L=0 at DONE
//     -> no effect mid-roll; L toggles exactly once in DONE; second nstart during ROLL ignored.
//  T5 Reset mid-op:
//     nreset low in step 3 of 8 -> outputs at reset values within same cycle; pending CPL lost.
//  T6 (PB3_ROLL_ABORT_EN):
//     nabort low in step 2 of 5 -> exactly 1 shift done, ndone next cycle, busy low after.

Source files
------------

// File: rtl/pb3_roll_pkg.sv
// rtl/pb3_roll_pkg.sv - shared encodings for the L/AC roll sequencer
// Purpose: FSM state encoding, roll mode constants and L flip-flop J/K
//          command encoding shared by pb3_l_roll_seq and pb3_l_jk_enc.
// Ports:   none (package).
package pb3_roll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RCL = 2'b00;  // rotate through L
    localparam logic [1:0] MODE_ROT = 2'b01;  // rotate AC only
    localparam logic [1:0] MODE_SHL = 2'b10;  // logical shift
    localparam logic [1:0] MODE_ASR = 2'b11;  // arithmetic shift

    // Encoded as {J,K} so the command drives the flip-flop bits directly.
    typedef enum logic [1:0] {
        LCMD_HOLD = 2'b00,
        LCMD_CLR  = 2'b01,
        LCMD_SET  = 2'b10,
        LCMD_TGL  = 2'b11
    } lcmd_t;

    // Microcode CLL/CPL: both together behave as clear-then-complement, i.e. set.
    function automatic lcmd_t micro_lcmd(input logic cll, input logic cpl);
        lcmd_t cmd;
        case ({cll, cpl})
            2'b10:   cmd = LCMD_CLR;
            2'b01:   cmd = LCMD_TGL;
            2'b11:   cmd = LCMD_SET;
            default: cmd = LCMD_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/pb3_l_jk_enc.sv
// rtl/pb3_l_jk_enc.sv - per-mode L J/K and AC fill encoder
// Purpose: combinational map from the current step context to the L flip-flop
//          J/K inputs and the bit shifted into AC.
// Ports:   i_step_active  a shift happens on the coming edge
//          i_mode/i_dir   latched roll mode and direction
//          i_fl           current L value
//          i_ac_msb/lsb   AC bit 15 / bit 0
//          i_cll/i_cpl    active-high clear/complement L (used when no step)
//          o_lj/o_lk      L flip-flop J/K
//          o_ac_fill      bit entering AC (bit 0 on left, bit 15 on right)
module pb3_l_jk_enc
    import pb3_roll_pkg::*;
(
    input  logic       i_step_active,
    input  logic [1:0] i_mode,
    input  logic       i_dir,
    input  logic       i_fl,
    input  logic       i_ac_msb,
    input  logic       i_ac_lsb,
    input  logic       i_cll,
    input  logic       i_cpl,
    output logic       o_lj,
    output logic       o_lk,
    output logic       o_ac_fill
);

    lcmd_t w_cmd;
    logic  w_out;

    always_comb begin
        // Bit leaving AC on this step.
        w_out     = i_dir ? i_ac_lsb : i_ac_msb;
        w_cmd     = micro_lcmd(i_cll, i_cpl);
        o_ac_fill = 1'b0;
        if (i_step_active) begin
            w_cmd = w_out ? LCMD_SET : LCMD_CLR;
            case (i_mode)
                MODE_RCL: o_ac_fill = i_fl;
                MODE_ROT: begin
                    o_ac_fill = w_out;
                    w_cmd     = LCMD_HOLD;
                end
                MODE_SHL: o_ac_fill = 1'b0;
                // Arithmetic: sign-extend on right, plain shift on left.
                default:  o_ac_fill = i_dir & i_ac_msb;
            endcase
        end
    end

    assign o_lj = w_cmd[1];
    assign o_lk = w_cmd[0];

endmodule

// File: rtl/pb3_l_roll_seq.sv
// rtl/pb3_l_roll_seq.sv - multi-cycle L/AC roll/shift sequencer
// Purpose: steps AC one bit per i_clk1 for N steps, drives L J/K, and
//          arbitrates microcode CLL#/CPL# against a running sequence.
// Option:  define PB3_ROLL_ABORT_EN to add i_nabort (abort a running roll).
// Ports:   i_clk1, i_nreset (async active low)
//          i_nstart, i_dir, i_mode, i_count   sequence request (count 0 = 2**CNT_W)
//          i_ncll, i_ncpl                    microcode clear/complement L, active low
//          i_fl, i_ac_msb, i_ac_lsb          L and AC edge bits
//          [i_nabort]                        abort, active low (option only)
//          o_lj, o_lk                        L flip-flop J/K
//          o_ac_shl, o_ac_shr, o_ac_fill     AC shift enables and fill bit
//          o_busy, o_ndone                   status
module pb3_l_roll_seq
    import pb3_roll_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             i_clk1,
    input  logic             i_nreset,
    input  logic             i_nstart,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_ncll,
    input  logic             i_ncpl,
    input  logic             i_fl,
    input  logic             i_ac_msb,
    input  logic             i_ac_lsb,
`ifdef PB3_ROLL_ABORT_EN
    input  logic             i_nabort,
`endif
    output logic             o_lj,
    output logic             o_lk,
    output logic             o_ac_shl,
    output logic             o_ac_shr,
    output logic             o_ac_fill,
    output logic             o_busy,
    output logic             o_ndone
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic             r_pend_cll;
    logic             r_pend_cpl;
    logic             w_abort;
    logic             w_step;
    logic             w_cll;
    logic             w_cpl;

`ifdef PB3_ROLL_ABORT_EN
    assign w_abort = (r_state == ST_ROLL) && !i_nabort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge i_clk1 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (!i_nstart) w_next = ST_ROLL;
            ST_ROLL: if (w_abort || (r_cnt == CNT_ONE)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Counter, latched request and pending microcode L operations.
    // A loaded count of 0 wraps on the first decrement, giving 2**CNT_W steps.
    always_ff @(posedge i_clk1 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_mode     <= MODE_RCL;
            r_pend_cll <= 1'b0;
            r_pend_cpl <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_nstart) begin
                        r_cnt  <= i_count;
                        r_dir  <= i_dir;
                        r_mode <= i_mode;
                    end
                end
                ST_ROLL: begin
                    r_cnt      <= r_cnt - CNT_ONE;
                    r_pend_cll <= r_pend_cll | ~i_ncll;
                    r_pend_cpl <= r_pend_cpl | ~i_ncpl;
                end
                default: begin
                    r_pend_cll <= 1'b0;
                    r_pend_cpl <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_step   = (r_state == ST_ROLL) && !w_abort;
        o_ac_shl = w_step & ~r_dir;
        o_ac_shr = w_step & r_dir;
        o_busy   = (r_state != ST_IDLE);
        o_ndone  = (r_state != ST_DONE);
        // Microcode L requests act live in IDLE, are deferred during ROLL,
        // and merge with anything deferred when DONE is reached.
        w_cll    = 1'b0;
        w_cpl    = 1'b0;
        if (r_state == ST_IDLE) begin
            w_cll = ~i_ncll;
            w_cpl = ~i_ncpl;
        end else if (r_state == ST_DONE) begin
            w_cll = r_pend_cll | ~i_ncll;
            w_cpl = r_pend_cpl | ~i_ncpl;
        end
    end

    pb3_l_jk_enc u_jk_enc (
        .i_step_active (w_step),
        .i_mode        (r_mode),
        .i_dir         (r_dir),
        .i_fl          (i_fl),
        .i_ac_msb      (i_ac_msb),
        .i_ac_lsb      (i_ac_lsb),
        .i_cll         (w_cll),
        .i_cpl         (w_cpl),
        .o_lj          (o_lj),
        .o_lk          (o_lk),
        .o_ac_fill     (o_ac_fill)
    );

endmodule
